// File: rtl/ifu_mem_rsp.sv
// ifu_mem_rsp: memory-side responder for the IFU fetch handshake.
// Accepts one fetch address per val/rdy handshake, forwards it to a memory
// port with variable grant and response latency, and presents the returned
// word on o_in_r. The word stays stable until the next accepted fetch.
// A completing response is bypassed straight to o_in_r so that a
// zero-wait-state memory sustains one fetch per cycle.
module ifu_mem_rsp #(
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_rd4ls_val,
    output logic        hs_ls4rd_rdy,
    input  logic [31:0] i_pc_nx,
    output logic [31:0] o_in_r,
    output logic        o_err,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_rerr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no outstanding fetch
        REQ  = 2'd1,   // address latched, waiting for grant
        RESP = 2'd2    // granted, waiting for read data
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_q;

    logic        rsp_done;
    logic        accept;
    logic        aligned;
    logic [31:0] pc_word;

    // A response only counts while a granted fetch is outstanding; rvalid
    // seen in IDLE or REQ (e.g. stale after a reset) is ignored.
    assign rsp_done = (state_q == RESP) && i_mem_rvalid;

    // Ready when nothing is outstanding, or the outstanding fetch completes
    // this cycle. Never ready in REQ.
    assign hs_ls4rd_rdy = (state_q == IDLE) || rsp_done;

    assign accept  = hs_rd4ls_val && hs_ls4rd_rdy;
    assign aligned = (i_pc_nx[1:0] == 2'b00);
    assign pc_word = {i_pc_nx[31:2], 2'b00};

    // A new aligned fetch is issued in its acceptance cycle; while waiting
    // for grant the latched address is held stable.
    assign o_mem_req  = (state_q == REQ) || (accept && aligned);
    assign o_mem_addr = (state_q == REQ) ? addr_q : pc_word;

    // Bypass the completing word so the IFU sees it in the same cycle.
    assign o_in_r = rsp_done ? i_mem_rdata : data_q;
    assign o_err  = rsp_done ? i_mem_rerr  : err_q;

    // Fetch FSM with address/data/error registers; a same-cycle acceptance
    // overrides the completion transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            data_q  <= NOP_INSN;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (i_mem_gnt) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (i_mem_rvalid) begin
                        data_q  <= i_mem_rdata;
                        err_q   <= i_mem_rerr;
                        state_q <= IDLE;
                    end
                end
                default: begin
                end
            endcase

            if (accept) begin
                if (aligned) begin
                    addr_q  <= pc_word;
                    state_q <= i_mem_gnt ? RESP : REQ;
                end else begin
                    // Misaligned fetch faults without touching memory; it
                    // also replaces a word completing in this cycle, which
                    // the IFU has already taken through the bypass.
                    data_q  <= 32'h0;
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end
            end
        end
    end

endmodule
